frag_tile_iterator: RTL
=======================

// Module: frag_tile_iterator
// PURPOSE
//  Parametrised successor to frag_iterator. Takes a fixed-point bounding box from triangle setup
//  and emits LANES horizontally adjacent fragment positions per beat, row by row, to the edge-test
//  stage. Supports raster or serpentine row order and downstream backpressure, and never wraps at
//  the top of the coordinate range.
// PARAMETERS
//  COORD_W     16  coordinate width in bits, unsigned fixed point
//  FRAC_W      4   fraction bits; one pixel step PIX = 1<<FRAC_W
//  LANES       4   fragments per beat along x; must be a power of two, >=1
//  SERPENTINE  0   0 = every row runs left to right; 1 = odd rows (row index from 0) run right to left
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 synchronous reset, active-high
//  nd         in   1                 new bounding box valid
//  us_rfd     out  1                 ready for a new box (upstream handshake)
//  fp_min_x   in   COORD_W           box min x, inclusive
//  fp_max_x   in   COORD_W           box max x, inclusive
//  fp_min_y   in   COORD_W           box min y, inclusive
//  fp_max_y   in   COORD_W           box max y, inclusive
//  ds_rfd     in   1                 downstream ready for a beat
//  rdy        out  1                 beat valid
//  fp_x       out  COORD_W           x of lane 0; lane i is at fp_x + i*PIX
//  fp_y       out  COORD_W           y of the beat
//  lane_mask  out  LANES             bit i set -> lane i is inside the box (fp_x + i*PIX <= max_x)
//  last       out  1                 final beat of the box
// BEHAVIOUR
//  - States: IDLE, RUN, DRAIN. Reset (any state) -> IDLE. Outputs after reset: us_rfd=1, rdy=0,
//    fp_x=0, fp_y=0, lane_mask=0, last=0. A box in progress at reset is abandoned with no beats left.
//  - IDLE: us_rfd=1. nd&&us_rfd latches all four bounds; us_rfd=0 from the next cycle.
//    Degenerate box (min_x>max_x or min_y>max_y) -> DRAIN, with no beats.
//    Otherwise -> RUN, with the first beat presented (rdy=1) on the cycle after acceptance.
//  - Beat bases per row: B_k = min_x + k*LANES*PIX, for k = 0..K, where
//    K = ((max_x-min_x)>>FRAC_W)>>log2(LANES). Rows: y = min_y + r*PIX while y <= max_y.
//  - Row order: raster visits k = 0..K. With SERPENTINE=1, odd r visits k = K..0. Beats positions
//    and masks are the same in both directions.
//  - All position and mask arithmetic is done at COORD_W+1 bits, so a step past 2^COORD_W-1 ends
//    the row or box and never wraps. Masks for lanes beyond the range are 0.
//  - Handshake: all outputs are registered. While rdy && !ds_rfd, all outputs stay stable.
//    On rdy && ds_rfd, the next beat is presented on the next cycle with no bubbles, giving one beat
//    per clock when ds_rfd is held high.
//  - last=1 only on the final beat: last row, final k in visit order. When that beat is accepted:
//    rdy=0 and go to DRAIN.
//  - DRAIN: lasts one cycle, outputs cleared, then IDLE (us_rfd=1). nd is ignored outside IDLE.
//  - Throughput floor: the second box's first beat comes no earlier than 3 cycles after the first
//    box's last beat is accepted.
// TESTING
//  T1 raster: box x 0x00..0x50, y 0x10..0x20, ds_rfd=1 -> 4 beats (x,y,mask):
//     (0x00,0x10,1111) (0x40,0x10,0011) (0x00,0x20,1111) (0x40,0x20,0011); last on beat 4 only.
//  T2 SERPENTINE=1, same box -> (0x00,0x10) (0x40,0x10) (0x40,0x20) (0x00,0x20); masks follow x.
//  T3 backpressure: T1 with ds_rfd toggling every cycle -> same 4 beats, each held stable while
//     ds_rfd=0, no beat lost or repeated.
//  T4 degenerate: min_x=0x30, max_x=0x20 -> rdy never asserts; us_rfd back to 1 within 3 cycles.
//  T5 range top: x 0xFFC0..0xFFF0, y 0xFFF0..0xFFF0 -> exactly 1 beat, x=0xFFC0, mask 1111,
//     last=1; no wrap to 0.
//  T6 reset mid-box: assert rst during beat 2 of T1 -> next cycle rdy=0, us_rfd=1, all outputs 0;
//     a new box then runs cleanly.

Source files
------------

// File: rtl/frag_tile_iterator.sv
// Fragment tile iterator: walks a fixed-point bounding box row by row and
// presents LANES horizontally adjacent fragment positions per beat.
//
// state   | meaning
// S_IDLE  | waiting for a new box (o_us_rfd=1)
// S_RUN   | presenting beats, advancing on each downstream accept
// S_DRAIN | one cycle with outputs cleared before returning to idle
module frag_tile_iterator #(
    parameter int COORD_W    = 16,
    parameter int FRAC_W     = 4,
    parameter int LANES      = 4,
    parameter int SERPENTINE = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_nd,
    output logic               o_us_rfd,
    input  logic [COORD_W-1:0] i_fp_min_x,
    input  logic [COORD_W-1:0] i_fp_max_x,
    input  logic [COORD_W-1:0] i_fp_min_y,
    input  logic [COORD_W-1:0] i_fp_max_y,
    input  logic               i_ds_rfd,
    output logic               o_rdy,
    output logic [COORD_W-1:0] o_fp_x,
    output logic [COORD_W-1:0] o_fp_y,
    output logic [LANES-1:0]   o_lane_mask,
    output logic               o_last
);

    localparam int LOG2L   = $clog2(LANES);
    localparam int STEP_SH = FRAC_W + LOG2L;
    localparam logic [COORD_W:0] PIX = {{COORD_W{1'b0}}, 1'b1} << FRAC_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    logic [COORD_W-1:0] r_min_x, r_max_x, r_max_y;
    logic [COORD_W-1:0] r_kmax;
    logic [COORD_W-1:0] r_k;
    logic [COORD_W:0]   r_y;
    logic               r_odd;
    logic               r_us_rfd, r_rdy, r_last;
    logic [COORD_W-1:0] r_fp_x, r_fp_y;
    logic [LANES-1:0]   r_mask;

    logic [COORD_W-1:0] w_in_diff, w_in_kmax;
    logic               w_degen;
    logic               w_rev, w_row_end;
    logic [COORD_W-1:0] w_bmin, w_bmax, w_bmaxy, w_bkmax;
    logic [COORD_W-1:0] w_nk;
    logic [COORD_W:0]   w_ny;
    logic               w_nodd, w_nrev;
    logic [COORD_W:0]   w_bx;
    logic [LANES-1:0]   w_mask;
    logic               w_nlast;

    assign w_in_diff = i_fp_max_x - i_fp_min_x;
    assign w_in_kmax = w_in_diff >> STEP_SH;
    assign w_degen   = (i_fp_min_x > i_fp_max_x) || (i_fp_min_y > i_fp_max_y);
    assign w_rev     = (SERPENTINE != 0) && r_odd;
    assign w_row_end = w_rev ? (r_k == '0) : (r_k == r_kmax);

    // Pick the next beat: the first beat of a fresh box in idle, otherwise the
    // successor of the current beat in visit order.
    always_comb begin
        w_bmin  = r_min_x;
        w_bmax  = r_max_x;
        w_bmaxy = r_max_y;
        w_bkmax = r_kmax;
        w_nk    = r_k;
        w_ny    = r_y;
        w_nodd  = r_odd;
        if (r_state == S_IDLE) begin
            w_bmin  = i_fp_min_x;
            w_bmax  = i_fp_max_x;
            w_bmaxy = i_fp_max_y;
            w_bkmax = w_in_kmax;
            w_nk    = '0;
            w_ny    = {1'b0, i_fp_min_y};
            w_nodd  = 1'b0;
        end else if (!w_row_end) begin
            w_nk = w_rev ? (r_k - COORD_W'(1)) : (r_k + COORD_W'(1));
        end else begin
            w_ny   = r_y + PIX;
            w_nodd = ~r_odd;
            w_nk   = ((SERPENTINE != 0) && !r_odd) ? r_kmax : '0;
        end
    end

    // Position, lane mask and last flag of the selected beat, all at COORD_W+1
    // bits so that lanes or rows past the top of the range never wrap.
    always_comb begin
        w_nrev = (SERPENTINE != 0) && w_nodd;
        w_bx   = {1'b0, w_bmin} + ({1'b0, w_nk} << STEP_SH);
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mask[i] = (w_bx + ((COORD_W+1)'(i) << FRAC_W)) <= {1'b0, w_bmax};
        end
        w_nlast = ((w_ny + PIX) > {1'b0, w_bmaxy}) &&
                  (w_nrev ? (w_nk == '0) : (w_nk == w_bkmax));
    end

    // Control FSM with registered handshake and beat outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_us_rfd <= 1'b1;
            r_rdy    <= 1'b0;
            r_fp_x   <= '0;
            r_fp_y   <= '0;
            r_mask   <= '0;
            r_last   <= 1'b0;
            r_min_x  <= '0;
            r_max_x  <= '0;
            r_max_y  <= '0;
            r_kmax   <= '0;
            r_k      <= '0;
            r_y      <= '0;
            r_odd    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_nd) begin
                        r_min_x  <= i_fp_min_x;
                        r_max_x  <= i_fp_max_x;
                        r_max_y  <= i_fp_max_y;
                        r_kmax   <= w_in_kmax;
                        r_us_rfd <= 1'b0;
                        if (w_degen) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_RUN;
                            r_rdy   <= 1'b1;
                            r_fp_x  <= w_bx[COORD_W-1:0];
                            r_fp_y  <= w_ny[COORD_W-1:0];
                            r_mask  <= w_mask;
                            r_last  <= w_nlast;
                            r_k     <= w_nk;
                            r_y     <= w_ny;
                            r_odd   <= w_nodd;
                        end
                    end
                end
                S_RUN: begin
                    if (i_ds_rfd) begin
                        if (r_last) begin
                            r_state <= S_DRAIN;
                            r_rdy   <= 1'b0;
                            r_fp_x  <= '0;
                            r_fp_y  <= '0;
                            r_mask  <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_fp_x <= w_bx[COORD_W-1:0];
                            r_fp_y <= w_ny[COORD_W-1:0];
                            r_mask <= w_mask;
                            r_last <= w_nlast;
                            r_k    <= w_nk;
                            r_y    <= w_ny;
                            r_odd  <= w_nodd;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_us_rfd <= 1'b1;
                    r_rdy    <= 1'b0;
                    r_fp_x   <= '0;
                    r_fp_y   <= '0;
                    r_mask   <= '0;
                    r_last   <= 1'b0;
                end
            endcase
        end
    end

    assign o_us_rfd    = r_us_rfd;
    assign o_rdy       = r_rdy;
    assign o_fp_x      = r_fp_x;
    assign o_fp_y      = r_fp_y;
    assign o_lane_mask = r_mask;
    assign o_last      = r_last;

endmodule
